// File: rtl/pkg_alu_defs.sv
`default_nettype none
// ============================================================================
// Module      : pkg_alu_defs
// Description : Shared definitions for the ALU issue/write-back stage:
//               opcode values, instruction field positions, FSM state
//               encoding and architectural flag bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_alu_defs;

  // Opcodes understood by the downstream ALU; anything above OP_MAX_LEGAL
  // is rejected at issue.
  localparam logic [3:0] OP_ADD       = 4'd0;
  localparam logic [3:0] OP_SUB       = 4'd1;
  localparam logic [3:0] OP_NOT       = 4'd2;
  localparam logic [3:0] OP_AND       = 4'd3;
  localparam logic [3:0] OP_OR        = 4'd4;
  localparam logic [3:0] OP_XOR       = 4'd5;
  localparam logic [3:0] OP_SLL       = 4'd6;
  localparam logic [3:0] OP_SRL       = 4'd7;
  localparam logic [3:0] OP_SRA       = 4'd8;
  localparam logic [3:0] OP_MAX_LEGAL = 4'd8;

  // Instruction field layout (32-bit instruction word).
  localparam int C_OP_W      = 4;
  localparam int C_REG_W     = 4;
  localparam int C_OP_MSB    = 31;
  localparam int C_RD_MSB    = 27;
  localparam int C_RS_MSB    = 23;
  localparam int C_RT_MSB    = 19;
  localparam int C_IMMSEL_B  = 15;
  localparam int C_IMM_MSB   = 14;

  // Issue FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } alu_state_e;

  // Bit positions inside flags_q = {C,S,V,Z}.
  localparam int C_FLAG_C = 3;
  localparam int C_FLAG_S = 2;
  localparam int C_FLAG_V = 1;
  localparam int C_FLAG_Z = 0;

endpackage : pkg_alu_defs
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : NREG x XLEN register file, two combinational read ports, a
//               combinational debug read port and one synchronous write
//               port. Entry 0 is never written, so it always reads zero.
//               All entries clear asynchronously on i_rst_n low.
// Ports       : i_clk, i_rst_n     - clock, async active-low clear
//               i_we/i_waddr/i_wdata - write port
//               i_raddr_a/o_rdata_a  - read port A
//               i_raddr_b/o_rdata_b  - read port B
//               i_dbg_addr/o_dbg_data - debug read port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr_a,
  input  logic [AW-1:0]   i_raddr_b,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b,
  output logic [XLEN-1:0] o_dbg_data
);

  logic [XLEN-1:0] r_mem [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      // Writes to R0 are dropped, keeping R0 at its reset value of zero.
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_unit
// Description : Issue/write-back stage around a clocked ALU. Accepts one
//               instruction over valid/ready, reads operands from the
//               register file, holds them for one ALU evaluation, then
//               captures result and flags and writes the result back.
//               Each instruction occupies the unit for exactly 3 cycles.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               instr_valid/data/ready     - instruction handshake
//               alu_operand_a/b, alu_opcode - issue to ALU
//               alu_result, alu_* flags    - ALU outputs
//               flags_q                    - architectural flags {C,S,V,Z}
//               wb_valid/addr/data         - write-back pulse
//               illegal                    - illegal-opcode pulse
//               busy                       - FSM not in IDLE
//               dbg_addr/dbg_data          - debug register read
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_unit
  import pkg_alu_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 16,
  parameter int IMM_W = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr_data,
  output logic            instr_ready,
  output logic [XLEN-1:0] alu_operand_a,
  output logic [XLEN-1:0] alu_operand_b,
  output logic [3:0]      alu_opcode,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_carry,
  input  logic            alu_sign,
  input  logic            alu_overflow,
  input  logic            alu_zero,
  output logic [3:0]      flags_q,
  output logic            wb_valid,
  output logic [3:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic            busy,
  input  logic [3:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic [C_OP_W-1:0]  w_op;
  logic [C_REG_W-1:0] w_rd;
  logic [C_REG_W-1:0] w_rs;
  logic [C_REG_W-1:0] w_rt;
  logic               w_imm_sel;
  logic [IMM_W-1:0]   w_imm;
  logic [XLEN-1:0]    w_imm_sext;
  logic               w_legal;
  logic               w_accept;

  assign w_op       = instr_data[C_OP_MSB -: C_OP_W];
  assign w_rd       = instr_data[C_RD_MSB -: C_REG_W];
  assign w_rs       = instr_data[C_RS_MSB -: C_REG_W];
  assign w_rt       = instr_data[C_RT_MSB -: C_REG_W];
  assign w_imm_sel  = instr_data[C_IMMSEL_B];
  assign w_imm      = instr_data[C_IMM_MSB -: IMM_W];
  assign w_imm_sext = {{(XLEN-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_legal    = (w_op <= OP_MAX_LEGAL);
  assign w_accept   = instr_valid && instr_ready;

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  alu_state_e      r_state;
  alu_state_e      w_next;
  logic [XLEN-1:0] w_rdata_a;
  logic [XLEN-1:0] w_rdata_b;
  logic            w_we;
  logic [3:0]      r_rd;

  // Write completes on the edge that returns to IDLE, so a following
  // instruction's operand read sees it without forwarding.
  assign w_we = (r_state == CAPT);

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (C_REG_W)
  ) u_regfile (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_we       (w_we),
    .i_waddr    (r_rd),
    .i_wdata    (alu_result),
    .i_raddr_a  (w_rs),
    .i_raddr_b  (w_rt),
    .i_dbg_addr (dbg_addr),
    .o_rdata_a  (w_rdata_a),
    .o_rdata_b  (w_rdata_b),
    .o_dbg_data (dbg_data)
  );

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        // Illegal opcodes are consumed but leave the FSM in IDLE.
        if (w_accept && w_legal) begin
          w_next = EXEC;
        end
      end
      EXEC:    w_next = CAPT;
      CAPT:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic [3:0]      r_opc;
  logic [3:0]      r_flags;
  logic            r_wb_valid;
  logic [3:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data;
  logic            r_illegal;
  logic [3:0]      w_alu_flags;

  always_comb begin
    w_alu_flags           = '0;
    w_alu_flags[C_FLAG_C] = alu_carry;
    w_alu_flags[C_FLAG_S] = alu_sign;
    w_alu_flags[C_FLAG_V] = alu_overflow;
    w_alu_flags[C_FLAG_Z] = alu_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa      <= '0;
      r_opb      <= '0;
      r_opc      <= '0;
      r_rd       <= '0;
      r_flags    <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal  <= w_accept && !w_legal;
      r_wb_valid <= (r_state == CAPT);
      if (w_accept && w_legal) begin
        r_opa <= w_rdata_a;
        r_opb <= w_imm_sel ? w_imm_sext : w_rdata_b;
        r_opc <= w_op;
        r_rd  <= w_rd;
      end
      if (r_state == CAPT) begin
        r_flags   <= w_alu_flags;
        r_wb_addr <= r_rd;
        r_wb_data <= alu_result;
      end
    end
  end

  assign alu_operand_a = r_opa;
  assign alu_operand_b = r_opb;
  assign alu_opcode    = r_opc;
  assign flags_q       = r_flags;
  assign wb_valid      = r_wb_valid;
  assign wb_addr       = r_wb_addr;
  assign wb_data       = r_wb_data;
  assign illegal       = r_illegal;

endmodule : alu_issue_unit
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_unit
// Description : Directed self-checking bench for alu_issue_unit with a
//               behavioural one-cycle-latency ALU stub and settable flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_unit;
  import pkg_alu_defs::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            instr_valid;
  logic [31:0]     instr_data;
  logic            instr_ready;
  logic [XLEN-1:0] alu_operand_a;
  logic [XLEN-1:0] alu_operand_b;
  logic [3:0]      alu_opcode;
  logic [XLEN-1:0] alu_result;
  logic            alu_carry;
  logic            alu_sign;
  logic            alu_overflow;
  logic            alu_zero;
  logic [3:0]      flags_q;
  logic            wb_valid;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic            busy;
  logic [3:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  int n_vec;
  int n_err;

  alu_issue_unit #(.XLEN(XLEN), .NREG(16), .IMM_W(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_ready   (instr_ready),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_opcode    (alu_opcode),
    .alu_result    (alu_result),
    .alu_carry     (alu_carry),
    .alu_sign      (alu_sign),
    .alu_overflow  (alu_overflow),
    .alu_zero      (alu_zero),
    .flags_q       (flags_q),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .illegal       (illegal),
    .busy          (busy),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: registered result, flags driven straight from bench variables.
  logic t_c, t_s, t_v, t_z;
  assign alu_carry    = t_c;
  assign alu_sign     = t_s;
  assign alu_overflow = t_v;
  assign alu_zero     = t_z;

  always_ff @(posedge clk) begin
    case (alu_opcode)
      OP_ADD:  alu_result <= alu_operand_a + alu_operand_b;
      OP_SUB:  alu_result <= alu_operand_a - alu_operand_b;
      OP_NOT:  alu_result <= ~alu_operand_a;
      OP_AND:  alu_result <= alu_operand_a & alu_operand_b;
      OP_OR:   alu_result <= alu_operand_a | alu_operand_b;
      OP_XOR:  alu_result <= alu_operand_a ^ alu_operand_b;
      OP_SLL:  alu_result <= alu_operand_a << alu_operand_b[4:0];
      OP_SRL:  alu_result <= alu_operand_a >> alu_operand_b[4:0];
      OP_SRA:  alu_result <= $signed(alu_operand_a) >>> alu_operand_b[4:0];
      default: alu_result <= '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; returns 1 time unit after the accept edge.
  task automatic issue(input logic [31:0] ins);
    int t;
    @(negedge clk);
    instr_data  = ins;
    instr_valid = 1'b1;
    t = 0;
    while (!instr_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, input string tag, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  logic [31:0] prog   [3];
  logic [3:0]  exp_wa [3];
  logic [31:0] exp_wd [3];
  int          acc    [3];

  initial begin
    int k, wbk, low;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0; dbg_addr = '0;
    t_c = 1'b0; t_s = 1'b0; t_v = 1'b0; t_z = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_wbv",   {31'd0, wb_valid}, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    check("rst_opa",   alu_operand_a, 32'd0);
    check("rst_opc",   {28'd0, alu_opcode}, 32'd0);
    rd_reg(4'd5, "rst_r5", 32'd0);

    // Scenario 1: ADD r1 = r0 + 5
    issue(32'h0100_8005);
    check("s1_opa",   alu_operand_a, 32'd0);
    check("s1_opb",   alu_operand_b, 32'd5);
    check("s1_opc",   {28'd0, alu_opcode}, 32'd0);
    check("s1_ready", {31'd0, instr_ready}, 32'd0);
    check("s1_busy",  {31'd0, busy}, 32'd1);
    step();
    check("s1_wbv_early", {31'd0, wb_valid}, 32'd0);
    step();
    check("s1_wbv",   {31'd0, wb_valid}, 32'd1);
    check("s1_wba",   {28'd0, wb_addr}, 32'd1);
    check("s1_wbd",   wb_data, 32'd5);
    rd_reg(4'd1, "s1_r1", 32'd5);
    step();
    check("s1_wbv_pulse", {31'd0, wb_valid}, 32'd0);

    // Scenario 2: sign-extended immediate, flags C=1 Z=1
    t_c = 1'b1; t_z = 1'b1;
    issue(32'h0210_FFFF);
    check("s2_opa", alu_operand_a, 32'd5);
    check("s2_opb", alu_operand_b, 32'hFFFF_FFFF);
    step(); step();
    check("s2_wbd",   wb_data, 32'd4);
    check("s2_flags", {28'd0, flags_q}, 32'h9);
    rd_reg(4'd2, "s2_r2", 32'd4);

    // Scenario 3: write to R0 is dropped but still reported
    issue(32'h0001_8005);
    step(); step();
    check("s3_wbv", {31'd0, wb_valid}, 32'd1);
    check("s3_wba", {28'd0, wb_addr}, 32'd0);
    check("s3_wbd", wb_data, 32'd5);
    rd_reg(4'd0, "s3_r0", 32'd0);

    // Scenario 4: illegal opcode; flag inputs changed to expose any capture
    t_c = 1'b0; t_z = 1'b0;
    issue(32'hF100_0000);
    check("s4_ill",   {31'd0, illegal}, 32'd1);
    check("s4_ready", {31'd0, instr_ready}, 32'd1);
    check("s4_busy",  {31'd0, busy}, 32'd0);
    step();
    check("s4_ill_pulse", {31'd0, illegal}, 32'd0);
    step(); step();
    check("s4_wbv",   {31'd0, wb_valid}, 32'd0);
    check("s4_flags", {28'd0, flags_q}, 32'h9);
    rd_reg(4'd1, "s4_r1", 32'd5);

    // Scenario 5: back-to-back with instr_valid held high
    prog[0] = 32'h1321_0000; exp_wa[0] = 4'd3; exp_wd[0] = 32'hFFFF_FFFF; // r3 = r2 - r1
    prog[1] = 32'h3431_8006; exp_wa[1] = 4'd4; exp_wd[1] = 32'd6;         // r4 = r3 & 6
    prog[2] = 32'h6540_8001; exp_wa[2] = 4'd5; exp_wd[2] = 32'd12;        // r5 = r4 << 1
    k = 0; wbk = 0; low = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    instr_data = prog[0];
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (wb_valid) begin
        if (wbk < 3) begin
          check("s5_wba", {28'd0, wb_addr}, {28'd0, exp_wa[wbk]});
          check("s5_wbd", wb_data, exp_wd[wbk]);
        end
        wbk++;
      end
      if (k > 0 && k < 3 && !instr_ready) low++;
      if (k < 3 && instr_ready) begin
        acc[k] = cyc;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) instr_data = prog[k];
        else       instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    check("s5_accepts", k, 32'd3);
    check("s5_wbcount", wbk, 32'd3);
    check("s5_gap01",   acc[1] - acc[0], 32'd3);
    check("s5_gap12",   acc[2] - acc[1], 32'd3);
    check("s5_rdylow",  low, 32'd4);
    rd_reg(4'd5, "s5_r5", 32'd12);

    // Scenario 6: reset during EXEC
    t_c = 1'b1;
    issue(32'h0170_8007);
    rst_n = 1'b0;
    #1;
    check("s6_busy",  {31'd0, busy}, 32'd0);
    check("s6_opa",   alu_operand_a, 32'd0);
    check("s6_opb",   alu_operand_b, 32'd0);
    check("s6_flags", {28'd0, flags_q}, 32'd0);
    rd_reg(4'd1, "s6_r1", 32'd0);
    rd_reg(4'd5, "s6_r5", 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("s6_wbv_rst", {31'd0, wb_valid}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("s6_ready", {31'd0, instr_ready}, 32'd1);
    repeat (3) begin
      step();
      check("s6_wbv_after", {31'd0, wb_valid}, 32'd0);
    end
    rd_reg(4'd3, "s6_r3", 32'd0);

    // Recovery after reset: r1 = r0 + 9
    t_c = 1'b0;
    issue(32'h0100_8009);
    step(); step();
    check("s6_rec_wbd", wb_data, 32'd9);
    rd_reg(4'd1, "s6_rec_r1", 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_issue_unit
`default_nettype wire
